// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: merges single-cycle pipeline writebacks with
// multi-cycle unit results held in a 2-entry FIFO, bounding how long the FIFO head can starve.
module wb_port_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_we,
  input  logic [ADDRESS_WIDTH-1:0] p_rd,
  input  logic [DATA_WIDTH-1:0]    p_wd,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [ADDRESS_WIDTH-1:0] m_rd,
  input  logic [DATA_WIDTH-1:0]    m_wd,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     stall,
  output logic [1:0]               fifo_count
);

  typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] rd_q [2];
  logic [DATA_WIDTH-1:0]    wd_q [2];
  logic                     wptr_q, rptr_q;
  logic [1:0]               count_q, count_d;
  logic [3:0]               starve_q, starve_d;
  logic                     grant_p, grant_f, enq, deq;
  logic [ADDRESS_WIDTH-1:0] src_rd;

  always_comb begin
    grant_p = 1'b0;
    grant_f = 1'b0;
    unique case (state_q)
      IDLE:    grant_p = p_we;
      DRAIN:   begin grant_f = !p_we; grant_p = p_we; end
      FORCE:   grant_f = 1'b1;
      default: ;
    endcase
    if (rst) begin
      grant_p = 1'b0;
      grant_f = 1'b0;
    end
  end

  assign m_ready = (count_q != 2'd2) && !rst;
  // Zero-destination results are consumed but never stored (x0 is not writable).
  assign enq     = m_valid && m_ready && (m_rd != '0);
  assign deq     = grant_f;
  assign count_d = count_q + 2'(enq) - 2'(deq);

  always_comb begin
    starve_d = starve_q;
    if (deq || count_d == 2'd0)          starve_d = 4'd0;
    else if (state_q == DRAIN && grant_p) starve_d = starve_q + 4'd1;

    if (count_d == 2'd0)                      state_d = IDLE;
    else if (starve_d == 4'(STARVE_LIMIT))    state_d = FORCE;
    else                                      state_d = DRAIN;
  end

  assign src_rd     = grant_f ? rd_q[rptr_q] : p_rd;
  assign a3         = src_rd;
  assign wd3        = grant_f ? wd_q[rptr_q] : p_wd;
  assign we3        = (grant_f || grant_p) && (src_rd != '0);
  assign stall      = grant_f && p_we;
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      if (enq) begin
        rd_q[wptr_q] <= m_rd;
        wd_q[wptr_q] <= m_wd;
        wptr_q       <= ~wptr_q;
      end
      if (deq) rptr_q <= ~rptr_q;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter; a queue-based reference model
// predicts each cycle's outputs and a separate monitor compares them.
module tb_wb_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p_we = 1'b0, m_valid = 1'b0;
  logic [AW-1:0] p_rd = '0, m_rd = '0;
  logic [DW-1:0] p_wd = '0, m_wd = '0;
  logic          m_ready, we3, stall;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [1:0]    fifo_count;

  wb_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .p_we(p_we), .p_rd(p_rd), .p_wd(p_wd),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_wd(m_wd),
    .we3(we3), .a3(a3), .wd3(wd3), .stall(stall), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  typedef struct { logic we; logic stall; logic [1:0] cnt; logic mr; } st_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  st_t st_q[$];
  wr_t wr_q[$];
  wr_t mq[$];        // model of queued multi-cycle results, oldest first
  int  starve = 0;
  logic hold = 1'b0, h_we = 1'b0;
  logic [AW-1:0] h_rd = '0;
  logic [DW-1:0] h_wd = '0;
  logic e_mr = 1'b0, e_acc = 1'b0;
  int  compared = 0, mismatched = 0;

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic pwe, input logic [AW-1:0] prd,
                       input logic [DW-1:0] pwd, input logic mv,
                       input logic [AW-1:0] mrd, input logic [DW-1:0] mwd);
    logic we_l, gf, gp, st_l;
    logic [AW-1:0] rd_l;
    logic [DW-1:0] wd_l;
    st_t s;
    wr_t w;
    int cnt;
    @(posedge clk); #1;
    we_l = pwe; rd_l = prd; wd_l = pwd;
    if (hold) begin we_l = h_we; rd_l = h_rd; wd_l = h_wd; end
    rst = r; p_we = we_l; p_rd = rd_l; p_wd = wd_l;
    m_valid = mv; m_rd = mrd; m_wd = mwd;
    cnt = mq.size();
    gf = 1'b0; gp = 1'b0;
    if (!r) begin
      if (cnt == 0)            gp = we_l;
      else if (starve == LIMIT) gf = 1'b1;
      else if (we_l)           gp = 1'b1;
      else                     gf = 1'b1;
    end
    st_l    = gf && we_l;
    e_mr    = !r && cnt < 2;
    e_acc   = mv && e_mr;
    s.cnt   = 2'(cnt);
    s.mr    = e_mr;
    s.stall = st_l;
    s.we    = 1'b0;
    if (gf) begin s.we = 1'b1; wr_q.push_back(mq[0]); end
    else if (gp && rd_l != '0) begin
      s.we = 1'b1; w.a = rd_l; w.d = wd_l; wr_q.push_back(w);
    end
    st_q.push_back(s);
    if (r) begin
      mq.delete(); starve = 0;
    end else begin
      if (gf) begin void'(mq.pop_front()); starve = 0; end
      else if (gp && cnt > 0) starve++;
      if (e_acc && mrd != '0) begin w.a = mrd; w.d = mwd; mq.push_back(w); end
      if (mq.size() == 0) starve = 0;
    end
    hold = st_l; h_we = we_l; h_rd = rd_l; h_wd = wd_l;
  endtask

  initial begin : monitor
    st_t s;
    wr_t w;
    forever begin
      @(negedge clk);
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("we3", DW'(we3), DW'(s.we));
        chk("stall", DW'(stall), DW'(s.stall));
        chk("fifo_count", DW'(fifo_count), DW'(s.cnt));
        chk("m_ready", DW'(m_ready), DW'(s.mr));
        if (we3) begin
          if (wr_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL we3_unexpected: got write a3=%0h wd3=%0h expected none", a3, wd3);
          end else begin
            w = wr_q.pop_front();
            chk("a3", DW'(a3), DW'(w.a));
            chk("wd3", wd3, w.d);
          end
        end else if (s.we && wr_q.size() > 0) void'(wr_q.pop_front());
      end
    end
  end

  initial begin : driver
    int n;
    @(posedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    // Pipeline write straight through with empty FIFO
    cycle(0, 1, 5'd5, 32'hA5, 0, 0, 0);
    // Multi-cycle result written one cycle after acceptance
    cycle(0, 0, 0, 0, 1, 5'd7, 32'h1234);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    // Starvation limit with pipeline writing continuously
    cycle(0, 1, 5'd1, 32'h11, 1, 5'd3, 32'hC3);
    cycle(0, 1, 5'd2, 32'h22, 1, 5'd4, 32'hC4);
    for (int i = 0; i < 14; i++) cycle(0, 1, 5'(8 + i), 32'h100 + i, 0, 0, 0);
    // Full FIFO: hold m_valid until accepted
    cycle(0, 1, 5'd1, 32'h1, 1, 5'd9, 32'h99);
    cycle(0, 1, 5'd2, 32'h2, 1, 5'd10, 32'hAA);
    n = 0;
    do begin
      cycle(0, 1, 5'd3, 32'h3, 1, 5'd11, 32'hBB);
      n++;
    end while (!e_acc && n < 20);
    chk("held_m_accepted", DW'(e_acc), DW'(1'b1));
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    // Zero-destination result consumed silently
    cycle(0, 0, 0, 0, 1, 5'd0, 32'hDEAD);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    // Reset with a full FIFO discards entries
    cycle(0, 1, 5'd6, 32'h6, 1, 5'd12, 32'hCC);
    cycle(0, 1, 5'd6, 32'h6, 1, 5'd13, 32'hDD);
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] mr;
      mr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), AW'($urandom),
            $urandom, $urandom_range(0, 1) == 1, mr, $urandom);
    end
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("pending_writes", DW'(wr_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
